// File: rtl/pipeline_pkg.sv
// Shared widths, constants and the ID/EX payload layout for the pipeline registers.
package pipeline_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CTRL_W        = 8;
    localparam int unsigned REG_W         = 5;
    localparam int unsigned CNT_W_DEFAULT = 16;

    localparam logic [REG_W-1:0]  REG_ZERO    = 5'd0;
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef struct packed {
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
    } ex_payload_t;

    localparam ex_payload_t BUBBLE_PAYLOAD = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage register.
interface id_ex_stage_reg_if import pipeline_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm_ext;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic              hold_in;
    logic              flush_in;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              id_stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_mem_read, id_ctrl,
               hold_in, flush_in,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_mem_read, ex_ctrl, id_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_mem_read, id_ctrl,
               hold_in, flush_in,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_mem_read, ex_ctrl, id_stall, bubble_count
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use_c
);

    logic rs_hit_c;
    logic rt_hit_c;

    assign rs_hit_c   = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit_c   = id_uses_rt && (id_rt == ex_rt);
    // $0 is hardwired, so a load targeting it never produces a dependency
    assign load_use_c = id_valid && ex_valid && ex_mem_read && (ex_rt != REG_ZERO)
                        && (rs_hit_c || rt_hit_c);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
module id_ex_stage_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_payload_t      ex_q;
    ex_payload_t      ex_d;
    logic             ex_valid_q;
    logic             ex_valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use_c;

    load_use_detect u_load_use_detect (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_q.mem_read),
        .ex_rt       (ex_q.rt),
        .load_use_c  (load_use_c)
    );

    // Next-state: flush beats hold, hold beats load-use, otherwise capture ID
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        cnt_d      = cnt_q;
        if (bus.flush_in) begin
            ex_valid_d = 1'b0;
            ex_d       = BUBBLE_PAYLOAD;
        end else if (!bus.hold_in) begin
            if (load_use_c) begin
                ex_valid_d = 1'b0;
                ex_d       = BUBBLE_PAYLOAD;
                cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                ex_valid_d    = bus.id_valid;
                ex_d.pc_plus4 = bus.id_pc_plus4;
                ex_d.rs_data  = bus.id_rs_data;
                ex_d.rt_data  = bus.id_rt_data;
                ex_d.imm      = bus.id_imm_ext;
                ex_d.rs       = bus.id_rs;
                ex_d.rt       = bus.id_rt;
                ex_d.rd       = bus.id_rd;
                ex_d.mem_read = bus.id_valid & bus.id_mem_read;
                ex_d.ctrl     = bus.id_valid ? bus.id_ctrl : BUBBLE_CTRL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= BUBBLE_PAYLOAD;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            cnt_q      <= cnt_d;
        end
    end

    // A flush must never be blocked, so it suppresses the stall
    assign bus.id_stall     = ~rst & ~bus.flush_in & (bus.hold_in | load_use_c);

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc_plus4  = ex_q.pc_plus4;
    assign bus.ex_rs_data   = ex_q.rs_data;
    assign bus.ex_rt_data   = ex_q.rt_data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Vector table plus scoreboard bench for id_ex_stage_reg; a 3-bit-counter copy exercises saturation.
module tb_id_ex_stage_reg;
    import pipeline_pkg::*;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        urs;
        logic        urt;
        logic        mr;
        logic [7:0]  ctrl;
        logic        hold;
        logic        flush;
        logic        e_stall;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mr;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    exp_t model = '0;
    exp_t sb[$];
    vec_t tab[22];

    id_ex_stage_reg_if               bus ();
    id_ex_stage_reg_if #(.CNT_W(3))  bus_s ();

    id_ex_stage_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_ex_stage_reg #(.CNT_W(3)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] imm,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic urs, input logic urt, input logic mr,
                                input logic [7:0] ctrl, input logic hold, input logic flush,
                                input logic es, input logic ev, input logic [15:0] ec);
        vec_t t;
        t.rst = r; t.valid = v; t.imm = imm; t.rs = rs; t.rt = rt; t.rd = rd;
        t.urs = urs; t.urt = urt; t.mr = mr; t.ctrl = ctrl; t.hold = hold; t.flush = flush;
        t.e_stall = es; t.e_valid = ev; t.e_cnt = ec;
        t.pc = '0; t.rsd = '0; t.rtd = '0;
        return t;
    endfunction

    // Reference behaviour of one clock edge
    function automatic exp_t model_next(input exp_t m, input vec_t v);
        exp_t n;
        logic lu;
        n  = m;
        lu = v.valid && m.valid && m.mr && (m.rt != 5'd0)
             && ((v.urs && v.rs == m.rt) || (v.urt && v.rt == m.rt));
        if (v.rst) begin
            n = '0;
        end else if (v.flush) begin
            n = '0;
            n.cnt = m.cnt;
            n.cnt_s = m.cnt_s;
        end else if (v.hold) begin
            n = m;
        end else if (lu) begin
            n = '0;
            n.cnt   = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
            n.cnt_s = (m.cnt_s == 3'h7) ? m.cnt_s : m.cnt_s + 3'd1;
        end else begin
            n.valid = v.valid;
            n.pc = v.pc; n.rsd = v.rsd; n.rtd = v.rtd; n.imm = v.imm;
            n.rs = v.rs; n.rt = v.rt; n.rd = v.rd;
            n.mr   = v.valid & v.mr;
            n.ctrl = v.valid ? v.ctrl : 8'h00;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [171:0] got, input logic [171:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %h required %h", name, got, exp);
        else
            passed++;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.id_valid = v.valid;     bus_s.id_valid = v.valid;
        bus.id_pc_plus4 = v.pc;     bus_s.id_pc_plus4 = v.pc;
        bus.id_rs_data = v.rsd;     bus_s.id_rs_data = v.rsd;
        bus.id_rt_data = v.rtd;     bus_s.id_rt_data = v.rtd;
        bus.id_imm_ext = v.imm;     bus_s.id_imm_ext = v.imm;
        bus.id_rs = v.rs;           bus_s.id_rs = v.rs;
        bus.id_rt = v.rt;           bus_s.id_rt = v.rt;
        bus.id_rd = v.rd;           bus_s.id_rd = v.rd;
        bus.id_uses_rs = v.urs;     bus_s.id_uses_rs = v.urs;
        bus.id_uses_rt = v.urt;     bus_s.id_uses_rt = v.urt;
        bus.id_mem_read = v.mr;     bus_s.id_mem_read = v.mr;
        bus.id_ctrl = v.ctrl;       bus_s.id_ctrl = v.ctrl;
        bus.hold_in = v.hold;       bus_s.hold_in = v.hold;
        bus.flush_in = v.flush;     bus_s.flush_in = v.flush;
    endtask

    // One cycle: drive, check stall mid-cycle, push expectation, compare after the edge
    task automatic step(input vec_t v, input logic e_stall, input string tag);
        exp_t e;
        exp_t got;
        drive(v);
        #2;
        check({tag, " id_stall"}, 172'(bus.id_stall), 172'(e_stall));
        model = model_next(model, v);
        sb.push_back(model);
        @(posedge clk);
        #1;
        got = {bus.ex_valid, bus.ex_pc_plus4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
               bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_mem_read, bus.ex_ctrl,
               bus.bubble_count, bus_s.bubble_count};
        e = sb.pop_front();
        check({tag, " ex_state"}, 172'(got), 172'(e));
    endtask

    initial begin
        vec_t v;
        //            rst v  imm           rs  rt  rd urs urt mr ctrl  hold flush | stall valid cnt
        tab[0]  = mk(1, 0, 32'h0,        0,  0,  0, 0, 0, 0, 8'h00, 0, 0,   0, 0, 0);
        tab[1]  = mk(1, 1, 32'h1234,     8,  8,  8, 1, 1, 1, 8'hFF, 1, 0,   0, 0, 0);
        tab[2]  = mk(0, 1, 32'hFFFF8000, 1,  2,  8, 1, 1, 0, 8'h5A, 0, 0,   0, 1, 0);
        tab[3]  = mk(0, 1, 32'h10,       3,  8,  0, 1, 0, 1, 8'hA5, 0, 0,   0, 1, 0);
        tab[4]  = mk(0, 1, 32'h20,       8,  9, 10, 1, 1, 0, 8'h33, 0, 0,   1, 0, 1);
        tab[5]  = mk(0, 1, 32'h20,       8,  9, 10, 1, 1, 0, 8'h33, 0, 0,   0, 1, 1);
        tab[6]  = mk(0, 1, 32'h30,       2,  0,  0, 1, 0, 1, 8'h11, 0, 0,   0, 1, 1);
        tab[7]  = mk(0, 1, 32'h40,       0,  5,  6, 1, 1, 0, 8'h22, 0, 0,   0, 1, 1);
        tab[8]  = mk(0, 1, 32'h50,       5, 12,  0, 1, 0, 1, 8'h44, 0, 0,   0, 1, 1);
        tab[9]  = mk(0, 1, 32'h60,      12,  3,  4, 1, 0, 0, 8'h66, 1, 0,   1, 1, 1);
        tab[10] = mk(0, 1, 32'h70,       7, 12,  4, 0, 1, 0, 8'h77, 1, 0,   1, 1, 1);
        tab[11] = mk(0, 0, 32'h80,       1,  1,  1, 1, 1, 1, 8'h88, 1, 0,   1, 1, 1);
        tab[12] = mk(0, 1, 32'h90,      12, 12,  4, 1, 1, 0, 8'h99, 1, 1,   0, 0, 1);
        tab[13] = mk(0, 0, 32'hA0,       3, 12,  0, 1, 0, 1, 8'hFF, 0, 0,   0, 0, 1);
        tab[14] = mk(0, 1, 32'hB0,       3, 12,  0, 1, 0, 1, 8'hC1, 0, 0,   0, 1, 1);
        tab[15] = mk(0, 1, 32'hC0,      12, 13,  0, 1, 0, 1, 8'hC2, 0, 0,   1, 0, 2);
        tab[16] = mk(0, 1, 32'hC0,      12, 13,  0, 1, 0, 1, 8'hC2, 0, 0,   0, 1, 2);
        tab[17] = mk(0, 1, 32'hD0,      13, 14,  0, 1, 0, 1, 8'hC3, 0, 0,   1, 0, 3);
        tab[18] = mk(0, 1, 32'hD0,      13, 14,  0, 1, 0, 1, 8'hC3, 0, 0,   0, 1, 3);
        tab[19] = mk(0, 1, 32'hE0,      14, 14, 15, 0, 0, 0, 8'hC4, 0, 0,   0, 1, 3);
        tab[20] = mk(0, 1, 32'hF0,      15,  1,  1, 1, 0, 1, 8'hC5, 0, 0,   0, 1, 3);
        tab[21] = mk(0, 1, 32'h100,      1,  2,  3, 1, 0, 0, 8'hC6, 0, 1,   0, 0, 3);

        for (int i = 0; i < 22; i++) begin
            v = tab[i];
            v.pc  = 32'(i * 4 + 4);
            v.rsd = $urandom();
            v.rtd = $urandom();
            step(v, v.e_stall, $sformatf("vec%0d", i));
            check($sformatf("vec%0d ex_valid", i), 172'(bus.ex_valid), 172'(v.e_valid));
            check($sformatf("vec%0d bubble_count", i), 172'(bus.bubble_count), 172'(v.e_cnt));
        end
        check("pass-through ex_imm", 172'(tab[2].imm), 172'(32'hFFFF8000));

        // Chained dependent loads: each costs one bubble; the 3-bit copy saturates
        v = mk(0, 1, 32'h200, 20, 20, 0, 1, 0, 1, 8'h81, 0, 0, 0, 0, 0);
        v.pc = 32'h400; v.rsd = $urandom(); v.rtd = $urandom();
        step(v, 1'b0, "sat_prime");
        for (int k = 0; k < 6; k++) begin
            step(v, 1'b1, $sformatf("sat%0d bubble", k));
            step(v, 1'b0, $sformatf("sat%0d advance", k));
        end
        check("sat small counter", 172'(bus_s.bubble_count), 172'(3'h7));
        check("sat wide counter", 172'(bus.bubble_count), 172'(16'd9));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register and load-use hazard detector, directly downstream of the sign extender.
- Captures decoded operands, the 32-bit extended immediate, register specifiers and control bits at the end of ID, and presents them to EX one cycle later.
- Detects load-use hazards against the instruction currently in EX, inserts a one-cycle bubble, and stalls PC and IF/ID.
- Honours a downstream hold and a branch flush.

Parameters:
- DATA_W, 32, operand, immediate and PC width.
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data  in  DATA_W  register-file read port A
- id_rt_data  in  DATA_W  register-file read port B
- id_imm_ext  in  DATA_W  output of the sign extender
- id_rs  in  5  source register specifier
- id_rt  in  5  source/target register specifier
- id_rd  in  5  destination specifier
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_mem_read  in  1  instruction is a load
- id_ctrl  in  CTRL_W  remaining control bits
- hold_in  in  1  EX/MEM cannot accept; freeze
- flush_in  in  1  branch resolved taken; kill the ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd  out  5  registered specifiers
- ex_mem_read  out  1  registered load flag
- ex_ctrl  out  CTRL_W  registered control bits
- id_stall  out  1  combinational; PC and IF/ID must not update
- bubble_count  out  CNT_W  load-use bubbles inserted since reset

Behaviour:
- One clock domain (Clk); reset (Rst) is synchronous and active-high.
- Reset: every registered output is cleared to 0, including ex_valid, ex_mem_read, ex_ctrl, all data and specifier fields, and bubble_count. id_stall is 0 while Rst is high.
- load_use is combinational and true when all of the following hold:
  - id_valid and ex_valid and ex_mem_read
  - ex_rt != 0
  - (id_uses_rs and id_rs == ex_rt) or (id_uses_rt and id_rt == ex_rt)
- id_stall = ~Rst & ~flush_in & (hold_in | load_use).
- Per-cycle action at the clock edge, in priority order:
  1. Rst: clear everything.
  2. flush_in: load a bubble. All outputs go to 0 (ex_valid = 0, ex_ctrl = 0, ex_mem_read = 0, data/specifier fields = 0). bubble_count is unchanged.
  3. hold_in: every register keeps its value, and id_stall = 1 for that cycle. load_use is not counted.
  4. load_use: load a bubble (same zeros as for flush). bubble_count increments, saturating at all-ones.
  5. Otherwise: capture all id_* inputs. ex_valid <= id_valid. If id_valid = 0, ex_ctrl and ex_mem_read are forced to 0.
- Latency is exactly 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle: after the bubble, ex_valid = 0, so load_use deasserts and the still-held ID instruction advances on the next edge.
- Back-to-back loads chaining (lw then a dependent lw) each cost one bubble.
- flush_in together with load_use or hold_in: flush wins. The bubble loads and id_stall = 0, so the fetch redirect proceeds.
- Register $0 never causes a hazard.
- The immediate passes through unmodified; no width change or re-extension.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_ZERO = 5'd0
  - CTRL_W default
  - a BUBBLE_CTRL constant (all zeros)
- Optional sub-module load_use_detect: purely combinational, produces load_use from the ID specifiers and the EX fields. The register logic and counter stay in id_ex_stage_reg.

Test Plan:
- Reset/pass-through: Rst high for 2 cycles, all outputs = 0. Then id_valid = 1, id_imm_ext = 32'hFFFF8000, id_rd = 5'd8, id_ctrl = 8'h5A → next cycle ex_imm = 32'hFFFF8000, ex_rd = 8, ex_ctrl = 8'h5A, ex_valid = 1.
- Load-use: lw $8 in EX (ex_mem_read = 1, ex_rt = 8), ID holds add with id_rs = 8, id_uses_rs = 1 → id_stall = 1 for exactly one cycle; next ex_valid = 0, ex_ctrl = 0; bubble_count 0→1; the add appears in EX one cycle later.
- No false hazard: ex_rt = 0 with id_rs = 0, and separately ex_mem_read = 0 with a matching rt → id_stall = 0, no bubble, bubble_count unchanged.
- Hold: hold_in = 1 for 3 cycles with changing id_* inputs → all ex_* stable, id_stall = 1 throughout, bubble_count unchanged even if load_use is true.
- Flush priority: flush_in = 1 together with load_use and hold_in → id_stall = 0, next ex_valid = 0, bubble_count unchanged.
- Saturation: preload via 65535 consecutive load-use bubbles (CNT_W = 16), then one more → bubble_count stays 16'hFFFF.
